// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the writeback arbiter.
//   wb_req_t      - one pending register-file write {rd, data}
//   wb_src_t      - which source owns the write port in a given cycle
//   wb_rd_onehot  - one-hot decode of a destination register index
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_NREGS  = 1 << WB_ADDR_W;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_FAST
    } wb_src_t;

    function automatic logic [WB_NREGS-1:0] wb_rd_onehot(input logic [WB_ADDR_W-1:0] rd);
        logic [WB_NREGS-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t for long-latency writeback results.
// Optional feature macro: WB_PENDING_MASK_EN (exports raw entries + occupancy
// mask so the parent can build the pending-destination mask).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   push_i, push_data_i   enqueue request/data (ignored when full)
//   pop_i                 dequeue request (ignored when empty)
//   head_o                oldest entry
//   full_o, empty_o       status
//   count_o               occupancy
//   entries_o, valid_o    storage and per-slot valid (WB_PENDING_MASK_EN only)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wb_req_t                  push_data_i,
    input  logic                     pop_i,
    output wb_req_t                  head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef WB_PENDING_MASK_EN
    ,
    output wb_req_t [DEPTH-1:0]      entries_o,
    output logic    [DEPTH-1:0]      valid_o
`endif
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Power-of-two depth: pointers wrap naturally at PW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only observed through the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

`ifdef WB_PENDING_MASK_EN
    // Slot i is occupied when its distance from the read pointer is below count.
    always_comb begin
        entries_o = '0;
        valid_o   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[i];
            valid_o[i]   = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q);
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage merging a single-cycle ALU result and a
// long-latency (valid/ready) result into the register-file write port.
// Optional feature macro: WB_PENDING_MASK_EN (drives PENDING from FIFO contents;
// otherwise PENDING is all-zeros and the hazard unit uses FIFO_COUNT != 0).
// Ports:
//   CLK, RST                        clock, asynchronous active-high reset
//   ALU_VALID, ALU_RD, ALU_DATA     ALU result (no backpressure)
//   LL_VALID, LL_READY, LL_RD, LL_DATA  long-path handshake (READY = FIFO not full)
//   ALU_STALL                       registered one-cycle request to idle the ALU
//   WE3, A3, WD3                    registered register-file write port
//   PENDING                         one-hot mask of queued destinations
//   FIFO_COUNT                      long-path buffer occupancy
// ADDRESS_WIDTH/DATA_WIDTH must match the wb_pkg widths carried by wb_req_t.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH    = WB_DATA_W,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            ALU_VALID,
    input  logic [ADDRESS_WIDTH-1:0]        ALU_RD,
    input  logic [DATA_WIDTH-1:0]           ALU_DATA,
    input  logic                            LL_VALID,
    output logic                            LL_READY,
    input  logic [ADDRESS_WIDTH-1:0]        LL_RD,
    input  logic [DATA_WIDTH-1:0]           LL_DATA,
    output logic                            ALU_STALL,
    output logic                            WE3,
    output logic [ADDRESS_WIDTH-1:0]        A3,
    output logic [DATA_WIDTH-1:0]           WD3,
    output logic [2**ADDRESS_WIDTH-1:0]     PENDING,
    output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);

    localparam int unsigned SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);
    localparam logic [SW-1:0] SW_ONE  = SW'(1);

    wb_req_t  alu_req, ll_req, head_req, sel_req;
    wb_src_t  src;
    logic     fifo_full, fifo_empty;
    logic     ll_xfer, fifo_push, fifo_pop, starve_win;

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic                     stall_q, stall_d;
    logic [SW-1:0]            starve_q, starve_d;

    assign alu_req  = '{rd: ALU_RD, data: ALU_DATA};
    assign ll_req   = '{rd: LL_RD,  data: LL_DATA};
    assign LL_READY = !fifo_full;
    assign ll_xfer  = LL_VALID && !fifo_full;

    always_comb begin
        src     = SRC_NONE;
        sel_req = alu_req;
        if (ALU_VALID) begin
            src     = SRC_ALU;
            sel_req = alu_req;
        end else if (!fifo_empty) begin
            src     = SRC_FIFO;
            sel_req = head_req;
        end else if (ll_xfer) begin
            src     = SRC_FAST;
            sel_req = ll_req;
        end
    end

    // A fast-path transfer bypasses the FIFO; every other accepted result queues.
    assign fifo_push  = ll_xfer && (src != SRC_FAST);
    assign fifo_pop   = (src == SRC_FIFO);
    assign starve_win = ALU_VALID && !fifo_empty;

    always_comb begin
        we_d = 1'b0;
        a_d  = a_q;
        wd_d = wd_q;
        if (src != SRC_NONE) begin
            we_d = (sel_req.rd != '0);
            a_d  = sel_req.rd;
            wd_d = sel_req.data;
        end
    end

    // Counter saturates at the limit so a protocol-violating ALU cannot
    // re-trigger the stall pulse every cycle.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (starve_win) begin
            starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + SW_ONE;
            stall_d  = (starve_q == LIMIT_M1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q     <= 1'b0;
            a_q      <= '0;
            wd_q     <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign WE3       = we_q;
    assign A3        = a_q;
    assign WD3       = wd_q;
    assign ALU_STALL = stall_q;

`ifdef WB_PENDING_MASK_EN
    wb_req_t [FIFO_DEPTH-1:0] fifo_entries;
    logic    [FIFO_DEPTH-1:0] fifo_valid;
`endif

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (fifo_push),
        .push_data_i (ll_req),
        .pop_i       (fifo_pop),
        .head_o      (head_req),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (FIFO_COUNT)
`ifdef WB_PENDING_MASK_EN
        ,
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
`endif
    );

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        PENDING = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i].rd != '0))
                PENDING = PENDING | wb_rd_onehot(fifo_entries[i].rd);
        end
    end
`else
    assign PENDING = '0;
`endif

    a_stall_respected: assert property (
        @(posedge CLK) disable iff (RST) ALU_STALL |-> !ALU_VALID
    ) else $error("ALU_VALID asserted while ALU_STALL was high");

    a_no_pending_hazard: assert property (
        @(posedge CLK) disable iff (RST) (ALU_VALID && (ALU_RD != '0)) |-> !PENDING[ALU_RD]
    ) else $error("ALU_RD targets a register still pending in the FIFO");

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ALU_VALID;
    logic [AW-1:0] ALU_RD;
    logic [DW-1:0] ALU_DATA;
    logic          LL_VALID;
    logic          LL_READY;
    logic [AW-1:0] LL_RD;
    logic [DW-1:0] LL_DATA;
    logic          ALU_STALL;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [31:0]   PENDING;
    logic [1:0]    FIFO_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    wb_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (2),
        .STARVE_LIMIT  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ALU_VALID  (ALU_VALID),
        .ALU_RD     (ALU_RD),
        .ALU_DATA   (ALU_DATA),
        .LL_VALID   (LL_VALID),
        .LL_READY   (LL_READY),
        .LL_RD      (LL_RD),
        .LL_DATA    (LL_DATA),
        .ALU_STALL  (ALU_STALL),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .PENDING    (PENDING),
        .FIFO_COUNT (FIFO_COUNT)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        ALU_VALID = av;
        ALU_RD    = ard;
        ALU_DATA  = ad;
        LL_VALID  = lv;
        LL_RD     = lrd;
        LL_DATA   = ld;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   pend_6, pend_16;
        ent_t          q[$];
        ent_t          ent;
        int            sent, got;
        logic          av, lv, fire;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldata;

`ifdef WB_PENDING_MASK_EN
        pend_6  = 32'h0000_0006;
        pend_16 = 32'h0000_0010;
`else
        pend_6  = 32'h0;
        pend_16 = 32'h0;
`endif

        // ---------------- reset state ----------------
        RST = 1'b1;
        idle();
        repeat (2) cyc();
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_stall", ALU_STALL, 0);
        check("rst_pending", PENDING, 0);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_ll_ready", LL_READY, 1);
        RST = 1'b0;
        cyc();
        check("post_rst_we3", WE3, 0);

        // ---------------- ALU only ----------------
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        cyc();
        check("alu_we3", WE3, 1);
        check("alu_a3", A3, 5);
        check("alu_wd3", WD3, 32'hDEADBEEF);
        drive(1'b1, 5'd0, 32'h0000_0055, 1'b0, '0, '0);
        cyc();
        check("alu_x0_we3", WE3, 0);

        // ---------------- fast path ----------------
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_1234);
        check("fast_ll_ready", LL_READY, 1);
        cyc();
        check("fast_we3", WE3, 1);
        check("fast_a3", A3, 7);
        check("fast_wd3", WD3, 32'h0000_1234);
        check("fast_count", FIFO_COUNT, 0);
        idle();
        cyc();
        check("fast_idle_we3", WE3, 0);

        // ---------------- backpressure ----------------
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h101);
        cyc();
        check("bp_a_a3", A3, 10);
        check("bp_a_count", FIFO_COUNT, 1);
        drive(1'b1, 5'd10, 32'hA1, 1'b1, 5'd2, 32'h102);
        check("bp_b_ready", LL_READY, 1);
        cyc();
        check("bp_b_count", FIFO_COUNT, 2);
        check("bp_b_pending", PENDING, pend_6);
        check("bp_b_wd3", WD3, 32'hA1);
        drive(1'b1, 5'd10, 32'hA2, 1'b1, 5'd3, 32'h103);
        check("bp_c_full_ready", LL_READY, 0);
        cyc();
        check("bp_c_count", FIFO_COUNT, 2);
        check("bp_c_wd3", WD3, 32'hA2);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h103);
        check("bp_d_full_ready", LL_READY, 0);
        cyc();
        check("bp_w1_we3", WE3, 1);
        check("bp_w1_a3", A3, 1);
        check("bp_w1_wd3", WD3, 32'h101);
        check("bp_w1_count", FIFO_COUNT, 1);
        check("bp_e_ready", LL_READY, 1);
        cyc();
        check("bp_w2_a3", A3, 2);
        check("bp_w2_wd3", WD3, 32'h102);
        check("bp_w2_count", FIFO_COUNT, 1);
        idle();
        cyc();
        check("bp_w3_we3", WE3, 1);
        check("bp_w3_a3", A3, 3);
        check("bp_w3_wd3", WD3, 32'h103);
        check("bp_w3_count", FIFO_COUNT, 0);
        cyc();
        check("bp_drained_we3", WE3, 0);

        // ---------------- x0 entry from the FIFO ----------------
        drive(1'b1, 5'd13, 32'hC0, 1'b1, 5'd0, 32'h77);
        cyc();
        check("x0q_count", FIFO_COUNT, 1);
        check("x0q_pending", PENDING, 0);
        idle();
        cyc();
        check("x0q_we3", WE3, 0);
        check("x0q_dequeued", FIFO_COUNT, 0);

        // ---------------- starvation guard (twice: counter must restart) ----------------
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd4, 32'h404 + r);
            cyc();
            check("stv_q_count", FIFO_COUNT, 1);
            check("stv_q_pending", PENDING, pend_16);
            check("stv_q_stall", ALU_STALL, 0);
            for (int k = 1; k <= 3; k++) begin
                drive(1'b1, 5'd11, 32'hB0 + k, 1'b0, '0, '0);
                cyc();
                check("stv_early_stall", ALU_STALL, 0);
                check("stv_alu_wd3", WD3, 32'hB0 + k);
            end
            drive(1'b1, 5'd11, 32'hB4, 1'b0, '0, '0);
            cyc();
            check("stv_stall", ALU_STALL, 1);
            check("stv_4th_a3", A3, 11);
            idle();
            cyc();
            check("stv_head_we3", WE3, 1);
            check("stv_head_a3", A3, 4);
            check("stv_head_wd3", WD3, 32'h404 + r);
            check("stv_stall_pulse", ALU_STALL, 0);
            check("stv_count", FIFO_COUNT, 0);
        end

        // ---------------- wrap-around with alternating ALU ----------------
        sent = 0;
        got  = 0;
        for (int c = 0; c < 100 && got < 10; c++) begin
            av    = (c % 2) == 1;
            lv    = sent < 10;
            lrd   = AW'(sent + 1);
            ldata = DW'(32'h1000 + sent * 17);
            drive(av, 5'd20, DW'(32'hE000 + c), lv, lrd, ldata);
            fire = lv && LL_READY;
            if (fire) begin
                q.push_back('{rd: lrd, data: ldata});
                sent++;
            end
            cyc();
            if (av) begin
                check("wrap_alu_we3", WE3, 1);
                check("wrap_alu_a3", A3, 20);
                check("wrap_alu_wd3", WD3, 32'hE000 + c);
            end else if (q.size() != 0) begin
                ent = q.pop_front();
                check("wrap_ll_we3", WE3, 1);
                check("wrap_ll_a3", A3, ent.rd);
                check("wrap_ll_wd3", WD3, ent.data);
                got++;
            end else begin
                check("wrap_idle_we3", WE3, 0);
            end
            check("wrap_count_model", FIFO_COUNT, q.size());
            check("wrap_count_bound", FIFO_COUNT <= 2, 1);
        end
        check("wrap_all_sent", sent, 10);
        check("wrap_all_written", got, 10);
        idle();
        cyc();

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 5'd12, 32'hD0, 1'b1, 5'd8, 32'h808);
        cyc();
        drive(1'b1, 5'd12, 32'hD1, 1'b1, 5'd9, 32'h909);
        cyc();
        check("mrst_pre_count", FIFO_COUNT, 2);
        check("mrst_pre_we3", WE3, 1);
        RST = 1'b1;
        #1;
        check("mrst_we3", WE3, 0);
        check("mrst_a3", A3, 0);
        check("mrst_count", FIFO_COUNT, 0);
        check("mrst_pending", PENDING, 0);
        check("mrst_stall", ALU_STALL, 0);
        idle();
        cyc();
        RST = 1'b0;
        cyc();
        check("mrst_after1_we3", WE3, 0);
        cyc();
        check("mrst_after2_we3", WE3, 0);
        check("mrst_after2_count", FIFO_COUNT, 0);
        check("mrst_after2_ready", LL_READY, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
